// File: rtl/hold_pkg.sv
// Shared definitions for the hold generator / receiver pair.
package hold_pkg;

    // Receiver state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        TAIL = 2'd2
    } hold_rx_state_t;

    // Generator state constants, kept here so both ends agree on one file
    localparam logic [1:0] GEN_ST_IDLE = 2'd0;
    localparam logic [1:0] GEN_ST_HOLD = 2'd1;
    localparam logic [1:0] GEN_ST_GAP  = 2'd2;

    // Two-bit saturating increment used for the per-frame toggle count
    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/hold_rx_if.sv
// Bundle between the hold generator (master) and the hold receiver (slave).
// frame_cnt exists only when HOLD_RX_STATS_EN is defined.
interface hold_rx_if #(
    parameter int unsigned LEN_W = 4
);
    logic             g_in;
    logic             f_in;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] len;
    logic             len_err;
    logic             f_err;
`ifdef HOLD_RX_STATS_EN
    logic [15:0]      frame_cnt;
`endif

    modport master (
        output g_in, f_in,
`ifdef HOLD_RX_STATS_EN
        input  frame_cnt,
`endif
        input  busy, done, len, len_err, f_err
    );

    modport slave (
        input  g_in, f_in,
`ifdef HOLD_RX_STATS_EN
        output frame_cnt,
`endif
        output busy, done, len, len_err, f_err
    );
endinterface

// File: rtl/hold_edge.sv
// Registers g_in/f_in once and derives rise, fall and toggle strobes.
module hold_edge (
    input  logic clk,
    input  logic rst,
    input  logic g_in,
    input  logic f_in,
    output logic rise,
    output logic fall,
    output logic tog
);
    logic g_d;
    logic f_d;

    // Previous-cycle copies of the inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_d <= 1'b0;
            f_d <= 1'b0;
        end else begin
            g_d <= g_in;
            f_d <= f_in;
        end
    end

    // Edge strobes compare the live input against last cycle's value
    always_comb begin
        rise = g_in & ~g_d;
        fall = ~g_in & g_d;
        tog  = f_in ^ f_d;
    end
endmodule

// File: rtl/hold_rx.sv
// Hold-frame receiver: measures the g_in high length of each frame and checks
// that f_in toggled exactly once. Optional HOLD_RX_STATS_EN adds a 16-bit
// completed-frame counter on the interface.
module hold_rx
    import hold_pkg::*;
#(
    parameter int unsigned EXP_LEN = 7,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned F_WIN   = 2
) (
    input  logic       clk,
    input  logic       rst,
    hold_rx_if.slave   bus
);
    localparam int unsigned WIN_W = (F_WIN < 2) ? 1 : $clog2(F_WIN + 1);

    logic rise;
    logic fall;
    logic tog;

    hold_rx_state_t   state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [1:0]       tcnt_q, tcnt_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             len_err_q, len_err_d;
    logic             f_err_q, f_err_d;
    logic [1:0]       tcnt_inc;
    logic             complete;

    hold_edge u_edge (
        .clk  (clk),
        .rst  (rst),
        .g_in (bus.g_in),
        .f_in (bus.f_in),
        .rise (rise),
        .fall (fall),
        .tog  (tog)
    );

    // State and frame bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            tcnt_q    <= 2'd0;
            win_q     <= '0;
            done_q    <= 1'b0;
            len_q     <= '0;
            len_err_q <= 1'b0;
            f_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            tcnt_q    <= tcnt_d;
            win_q     <= win_d;
            done_q    <= done_d;
            len_q     <= len_d;
            len_err_q <= len_err_d;
            f_err_q   <= f_err_d;
        end
    end

    // Next-state logic; completion results are captured into the output registers
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        tcnt_d    = tcnt_q;
        win_d     = win_q;
        done_d    = 1'b0;
        len_d     = len_q;
        len_err_d = len_err_q;
        f_err_d   = f_err_q;
        complete  = 1'b0;
        // Toggle count including this cycle's toggle, so a toggle on the
        // closing cycle still belongs to the ending frame
        tcnt_inc  = tog ? sat_inc2(tcnt_q) : tcnt_q;

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    cnt_d   = LEN_W'(1);
                    sat_d   = 1'b0;
                    tcnt_d  = 2'd0;
                end
            end
            HIGH: begin
                tcnt_d = tcnt_inc;
                if (fall) begin
                    if (tcnt_inc != 2'd0) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d = TAIL;
                        win_d   = WIN_W'(F_WIN);
                    end
                end else if (cnt_q == '1) begin
                    sat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + LEN_W'(1);
                end
            end
            TAIL: begin
                tcnt_d = tcnt_inc;
                if (win_q != '0) begin
                    win_d = win_q - WIN_W'(1);
                end
                if (rise) begin
                    // Early next frame closes this one and restarts counting
                    complete = 1'b1;
                    state_d  = HIGH;
                    cnt_d    = LEN_W'(1);
                    sat_d    = 1'b0;
                    tcnt_d   = 2'd0;
                end else if (tog || win_q <= WIN_W'(1)) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            done_d    = 1'b1;
            len_d     = cnt_q;
            len_err_d = (cnt_q != LEN_W'(EXP_LEN)) | sat_q;
            f_err_d   = (tcnt_inc != 2'd1);
        end
    end

`ifdef HOLD_RX_STATS_EN
    logic [15:0] frame_cnt_q;

    // Completed-frame counter, wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= 16'd0;
        end else if (complete) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
`endif

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.len     = len_q;
    assign bus.len_err = len_err_q;
    assign bus.f_err   = f_err_q;
endmodule

// File: tb/tb_hold_rx.sv
// Directed bench for hold_rx with EXP_LEN=7, LEN_W=4, F_WIN=2.
module tb_hold_rx;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   step;
    int   n_done;
    int   done_step;
    logic f_lvl;

    hold_rx_if #(.LEN_W(4)) bus ();

    hold_rx #(
        .EXP_LEN (7),
        .LEN_W   (4),
        .F_WIN   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs; outputs are looked at 1 time unit after the edge
    task automatic drive(input logic g, input logic f);
        bus.g_in = g;
        bus.f_in = f;
        @(posedge clk);
        #1;
        step++;
        if (bus.done === 1'b1) begin
            n_done++;
            done_step = step;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.g_in = 1'b0;
        bus.f_in = 1'b0;
        f_lvl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", bus.done); end
        total++; if (bus.len !== 4'd0) begin bad++; $display("FAIL reset_len got=%0d want=0", bus.len); end
        total++; if (bus.len_err !== 1'b0) begin bad++; $display("FAIL reset_len_err got=%0b want=0", bus.len_err); end
        total++; if (bus.f_err !== 1'b0) begin bad++; $display("FAIL reset_f_err got=%0b want=0", bus.f_err); end
`ifdef HOLD_RX_STATS_EN
        total++; if (bus.frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d want=0", bus.frame_cnt); end
`endif
        rst = 1'b0;
        drive(1'b0, f_lvl);
    endtask

    // 7 high cycles, toggle on the 3rd: clean frame, done the cycle after fall
    task automatic test_nominal();
        int s0;
        n_done = 0;
        done_step = -1;
        drive(1'b0, f_lvl);
        s0 = step + 1;
        for (int i = 1; i <= 7; i++) begin
            if (i == 3) f_lvl = ~f_lvl;
            drive(1'b1, f_lvl);
            if (i == 4) begin
                total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL nom_busy got=%0b want=1", bus.busy); end
            end
        end
        for (int i = 0; i < 4; i++) drive(1'b0, f_lvl);
        total++; if (n_done != 1) begin bad++; $display("FAIL nom_ndone got=%0d want=1", n_done); end
        total++; if (done_step != s0 + 7) begin bad++; $display("FAIL nom_when got=%0d want=%0d", done_step, s0 + 7); end
        total++; if (bus.len !== 4'd7) begin bad++; $display("FAIL nom_len got=%0d want=7", bus.len); end
        total++; if (bus.len_err !== 1'b0) begin bad++; $display("FAIL nom_len_err got=%0b want=0", bus.len_err); end
        total++; if (bus.f_err !== 1'b0) begin bad++; $display("FAIL nom_f_err got=%0b want=0", bus.f_err); end
    endtask

    // 5 high cycles, toggle one cycle after fall: completes from TAIL
    task automatic test_late_toggle();
        int s0;
        n_done = 0;
        done_step = -1;
        s0 = step + 1;
        for (int i = 0; i < 5; i++) drive(1'b1, f_lvl);
        drive(1'b0, f_lvl);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL late_tail_busy got=%0b want=1", bus.busy); end
        f_lvl = ~f_lvl;
        drive(1'b0, f_lvl);
        for (int i = 0; i < 3; i++) drive(1'b0, f_lvl);
        total++; if (n_done != 1) begin bad++; $display("FAIL late_ndone got=%0d want=1", n_done); end
        total++; if (done_step != s0 + 6) begin bad++; $display("FAIL late_when got=%0d want=%0d", done_step, s0 + 6); end
        total++; if (bus.len !== 4'd5) begin bad++; $display("FAIL late_len got=%0d want=5", bus.len); end
        total++; if (bus.len_err !== 1'b1) begin bad++; $display("FAIL late_len_err got=%0b want=1", bus.len_err); end
        total++; if (bus.f_err !== 1'b0) begin bad++; $display("FAIL late_f_err got=%0b want=0", bus.f_err); end
    endtask

    // 7 high cycles, no toggle: window of 2 runs out
    task automatic test_no_toggle();
        int s0;
        n_done = 0;
        done_step = -1;
        s0 = step + 1;
        for (int i = 0; i < 7; i++) drive(1'b1, f_lvl);
        drive(1'b0, f_lvl);
        drive(1'b0, f_lvl);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL notog_busy got=%0b want=1", bus.busy); end
        drive(1'b0, f_lvl);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL notog_idle got=%0b want=0", bus.busy); end
        for (int i = 0; i < 2; i++) drive(1'b0, f_lvl);
        total++; if (n_done != 1) begin bad++; $display("FAIL notog_ndone got=%0d want=1", n_done); end
        total++; if (done_step != s0 + 9) begin bad++; $display("FAIL notog_when got=%0d want=%0d", done_step, s0 + 9); end
        total++; if (bus.len !== 4'd7) begin bad++; $display("FAIL notog_len got=%0d want=7", bus.len); end
        total++; if (bus.len_err !== 1'b0) begin bad++; $display("FAIL notog_len_err got=%0b want=0", bus.len_err); end
        total++; if (bus.f_err !== 1'b1) begin bad++; $display("FAIL notog_f_err got=%0b want=1", bus.f_err); end
    endtask

    // 20 high cycles, two toggles: length saturates at 15
    task automatic test_saturate();
        int s0;
        n_done = 0;
        done_step = -1;
        s0 = step + 1;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3 || i == 10) f_lvl = ~f_lvl;
            drive(1'b1, f_lvl);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, f_lvl);
        total++; if (n_done != 1) begin bad++; $display("FAIL sat_ndone got=%0d want=1", n_done); end
        total++; if (done_step != s0 + 20) begin bad++; $display("FAIL sat_when got=%0d want=%0d", done_step, s0 + 20); end
        total++; if (bus.len !== 4'd15) begin bad++; $display("FAIL sat_len got=%0d want=15", bus.len); end
        total++; if (bus.len_err !== 1'b1) begin bad++; $display("FAIL sat_len_err got=%0b want=1", bus.len_err); end
        total++; if (bus.f_err !== 1'b1) begin bad++; $display("FAIL sat_f_err got=%0b want=1", bus.f_err); end
    endtask

    // Fall then rise one cycle later: first frame closes on the rise, second counts from 1
    task automatic test_back_to_back();
        int s0;
        n_done = 0;
        done_step = -1;
        s0 = step + 1;
        for (int i = 0; i < 4; i++) drive(1'b1, f_lvl);
        drive(1'b0, f_lvl);
        drive(1'b1, f_lvl);
        total++; if (done_step != s0 + 5) begin bad++; $display("FAIL b2b_when1 got=%0d want=%0d", done_step, s0 + 5); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%0b want=1", bus.busy); end
        total++; if (bus.len !== 4'd4) begin bad++; $display("FAIL b2b_len1 got=%0d want=4", bus.len); end
        total++; if (bus.len_err !== 1'b1) begin bad++; $display("FAIL b2b_len_err1 got=%0b want=1", bus.len_err); end
        total++; if (bus.f_err !== 1'b1) begin bad++; $display("FAIL b2b_f_err1 got=%0b want=1", bus.f_err); end
        for (int i = 1; i <= 6; i++) begin
            if (i == 1) f_lvl = ~f_lvl;
            drive(1'b1, f_lvl);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, f_lvl);
        total++; if (n_done != 2) begin bad++; $display("FAIL b2b_ndone got=%0d want=2", n_done); end
        total++; if (done_step != s0 + 12) begin bad++; $display("FAIL b2b_when2 got=%0d want=%0d", done_step, s0 + 12); end
        total++; if (bus.len !== 4'd7) begin bad++; $display("FAIL b2b_len2 got=%0d want=7", bus.len); end
        total++; if (bus.len_err !== 1'b0) begin bad++; $display("FAIL b2b_len_err2 got=%0b want=0", bus.len_err); end
        total++; if (bus.f_err !== 1'b0) begin bad++; $display("FAIL b2b_f_err2 got=%0b want=0", bus.f_err); end
    endtask

    // Reset in the middle of a frame, then three clean frames
    task automatic test_mid_reset();
        n_done = 0;
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) f_lvl = ~f_lvl;
            drive(1'b1, f_lvl);
        end
        rst = 1'b1;
        bus.g_in = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mrst_busy got=%0b want=0", bus.busy); end
        total++; if (bus.len !== 4'd0) begin bad++; $display("FAIL mrst_len got=%0d want=0", bus.len); end
        total++; if (bus.len_err !== 1'b0) begin bad++; $display("FAIL mrst_len_err got=%0b want=0", bus.len_err); end
        total++; if (bus.f_err !== 1'b0) begin bad++; $display("FAIL mrst_f_err got=%0b want=0", bus.f_err); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        f_lvl = bus.f_in;
        for (int i = 0; i < 4; i++) drive(1'b0, f_lvl);
        total++; if (n_done != 0) begin bad++; $display("FAIL mrst_nodone got=%0d want=0", n_done); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL mrst_done got=%0b want=0", bus.done); end
        for (int k = 0; k < 3; k++) begin
            for (int i = 1; i <= 7; i++) begin
                if (i == 3) f_lvl = ~f_lvl;
                drive(1'b1, f_lvl);
            end
            for (int i = 0; i < 3; i++) drive(1'b0, f_lvl);
        end
        total++; if (n_done != 3) begin bad++; $display("FAIL mrst_frames got=%0d want=3", n_done); end
        total++; if (bus.len !== 4'd7) begin bad++; $display("FAIL mrst_len7 got=%0d want=7", bus.len); end
`ifdef HOLD_RX_STATS_EN
        total++; if (bus.frame_cnt !== 16'd3) begin bad++; $display("FAIL mrst_frame_cnt got=%0d want=3", bus.frame_cnt); end
`endif
    endtask

    initial begin
        total = 0;
        bad = 0;
        step = 0;
        n_done = 0;
        done_step = -1;
        test_reset();
        test_nominal();
        test_late_toggle();
        test_no_toggle();
        test_saturate();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hold_rx.md
HOLD_RX -- requirements
Module: hold_rx

Interface
REQ-001 SHALL have parameter EXP_LEN, default 7, expected number of cycles g_in is high per frame.
REQ-002 SHALL have parameter LEN_W, default 4, width of the length counter and len output.
REQ-003 SHALL have parameter F_WIN, default 2, cycles after g_in falls within which the f_in toggle is still accepted.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port g_in  input  1  frame-hold level from the hold generator (same clock domain).
REQ-007 SHALL have port f_in  input  1  per-frame toggle from the hold generator.
REQ-008 SHALL have port busy  output  1  high while a frame is being received (states HIGH and TAIL).
REQ-009 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-010 SHALL have port len  output  LEN_W  g_in high length of the last completed frame; updated with done.
REQ-011 SHALL have port len_err  output  1  valid with done: len != EXP_LEN, or counter saturated.
REQ-012 SHALL have port f_err  output  1  valid with done: f_in did not toggle exactly once in the frame.
REQ-013 SHALL have port frame_cnt  output  16  completed-frame count (present only with HOLD_RX_STATS_EN).

Function
REQ-014 SHALL register g_in and f_in into g_d and f_d each cycle; rise = g_in & ~g_d, fall = ~g_in & g_d, tog = f_in ^ f_d.
REQ-015 SHALL implement states IDLE, HIGH, TAIL in a registered state machine.
REQ-016 IDLE: on rise go to HIGH, load cnt=1, clear toggle count; otherwise stay, ignore tog.
REQ-017 HIGH: while g_in high, cnt increments, saturating at all-ones; each tog increments a 2-bit saturating toggle count.
REQ-018 HIGH on fall: if toggle count >= 1, complete frame next cycle and go to IDLE; else go to TAIL with window counter = F_WIN.
REQ-019 TAIL: tog counts; window decrements each cycle; completes when toggle seen or window reaches 0, then IDLE.
REQ-020 TAIL with rise (new frame before window expiry): SHALL complete current frame in that cycle and enter HIGH with cnt=1 in the same transition.
REQ-021 Completion SHALL assert done for exactly one cycle with len=cnt, len_err=(cnt!=EXP_LEN)|saturated, f_err=(toggle count != 1).
REQ-022 tog in the same cycle as fall SHALL count toward the ending frame.
REQ-023 len, len_err, f_err SHALL hold their values until the next done.

Reset
REQ-024 rst SHALL force state IDLE, g_d=0, f_d=0, cnt=0, busy=0, done=0, len=0, len_err=0, f_err=0, frame_cnt=0.
REQ-025 rst mid-frame SHALL abandon the frame with no done pulse; first frame after release requires a fresh rise.

Configuration
REQ-026 With HOLD_RX_STATS_EN defined, frame_cnt SHALL increment by 1 (wrapping at 16'hFFFF -> 0) on every done; without it, the port and counter SHALL not exist.

Structure
REQ-027 State encoding (hold_rx_state_t: IDLE=2'd0, HIGH=2'd1, TAIL=2'd2) SHALL live in shared package hold_pkg alongside generator state constants.
REQ-028 Edge detection SHALL be a sub-module hold_edge (registered input, rise/fall/tog outputs); the rest is flat.

Verification
REQ-029 g_in high 7 cycles, f_in toggles during cycle 3 -> one done, len=7, len_err=0, f_err=0, done one cycle after g_in falls.
REQ-030 g_in high 5 cycles, f_in toggles 1 cycle after fall -> done at toggle+1, len=5, len_err=1, f_err=0.
REQ-031 g_in high 7 cycles, no toggle -> TAIL for 2 cycles, done with f_err=1, len_err=0.
REQ-032 g_in high 20 cycles (LEN_W=4) with two toggles -> len=15, len_err=1, f_err=1.
REQ-033 g_in falls then rises 1 cycle later, no toggle -> done with f_err=1 in rise cycle, busy stays high, second frame counted from 1.
REQ-034 rst pulse at cycle 4 of frame -> no done, all outputs 0; with HOLD_RX_STATS_EN, 3 clean frames -> frame_cnt=3.
